// File: rtl/adc_spi_pkg.sv
// Shared types and frame constants for the 3-wire ADC control-port responder.
package adc_spi_pkg;

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_e;

  localparam logic [4:0] INSTR_BITS = 5'd8;
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic       RW_READ    = 1'b1;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin, plus level/rise/fall taken
// against a third registered copy.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], pin};

  // Reset to 0 so a chip select that is already low at reset release does
  // not look like a fresh falling edge; a new frame needs a real csbn fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc_spi_responder.sv
// Target side of the csbn/sclk/sdio ADC control port: oversampled on clk_clk,
// decodes 16-bit read/write frames into an 8-bit register file.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  CHIP_ID   = 8'hA5,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  adc_csbn,
  input  logic                  adc_sclk,
  input  logic                  adc_sdio_in,
  output logic                  adc_sdio_out,
  output logic                  adc_sdio_oe,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  frame_err
);

  // Pin order in the synchronizer array: [2]=csbn, [1]=sclk, [0]=sdio.
  logic [2:0] pin_lvl, pin_rise, pin_fall;

  spi_pin_sync u_sync [2:0] (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .pin   ({adc_csbn, adc_sclk, adc_sdio_in}),
    .level (pin_lvl),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  logic cs_rise, cs_fall, sck_rise, sck_fall, sdi;
  logic unused_pins;

  // A csbn edge in the same cycle as an sclk edge wins; the sclk edge is dropped.
  assign cs_rise     = pin_rise[2];
  assign cs_fall     = pin_fall[2];
  assign sck_rise    = pin_rise[1] & ~cs_fall & ~pin_lvl[2];
  assign sck_fall    = pin_fall[1] & ~cs_fall & ~pin_lvl[2];
  assign sdi         = pin_lvl[0];
  assign unused_pins = ^{pin_lvl[1], pin_rise[0], pin_fall[0]};

  state_e                      state_q, state_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic [7:0]                  rx_q, rx_d, tx_q, tx_d;
  logic                        rw_q, rw_d;
  logic [6:0]                  addr_q, addr_d;
  logic                        oe_q, oe_d, sdo_q, sdo_d;
  logic                        wr_pend_q, wr_pend_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic [6:0]                  wr_addr_q, wr_addr_d;
  logic [7:0]                  wr_data_q, wr_data_d;
  logic                        frame_err_q, frame_err_d;
  logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;
  logic [7:0]                  rx_byte, rd_val;

  assign rx_byte = {rx_q[6:0], sdi};

  // Read data for the address completing on this rise; unimplemented reads 0.
  always_comb begin
    rd_val = 8'h00;
    if (rx_byte[6:0] == 7'd0) rd_val = CHIP_ID;
    for (int i = 1; i < NUM_REGS; i++)
      if (rx_byte[6:0] == 7'(i)) rd_val = regs_q[i];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    oe_d        = oe_q;
    sdo_d       = sdo_q;
    wr_pend_d   = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    // Register 0 and out-of-range addresses still strobe but never store.
    if (wr_pend_q) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = addr_q;
      wr_data_d   = rx_q;
      for (int i = 1; i < NUM_REGS; i++)
        if (addr_q == 7'(i)) regs_d[i] = rx_q;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = INSTR;
          cnt_d   = '0;
          rx_d    = '0;
        end
      end
      INSTR: begin
        if (cs_rise) begin
          frame_err_d = (cnt_q != 5'd0);
          state_d     = IDLE;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          rx_d  = rx_byte;
          if (cnt_q == INSTR_BITS - 5'd1) begin
            rw_d    = rx_byte[7];
            addr_d  = rx_byte[6:0];
            tx_d    = (rx_byte[7] == RW_READ) ? rd_val : 8'h00;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          frame_err_d = (cnt_q != FRAME_BITS);
          state_d     = IDLE;
        end else if (sck_rise && cnt_q != FRAME_BITS) begin
          cnt_d = cnt_q + 5'd1;
          rx_d  = rx_byte;
          if (cnt_q == FRAME_BITS - 5'd1 && rw_q != RW_READ) begin
            wr_pend_d = 1'b1;
            state_d   = DONE;
          end
        end else if (sck_fall && rw_q == RW_READ) begin
          // The fall after the last rise releases the pin and ends the frame.
          if (cnt_q == FRAME_BITS) begin
            oe_d    = 1'b0;
            state_d = DONE;
          end else begin
            oe_d  = 1'b1;
            sdo_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) oe_d = 1'b0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      oe_q        <= 1'b0;
      sdo_q       <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == 0) ? CHIP_ID : RESET_VAL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      oe_q        <= oe_d;
      sdo_q       <= sdo_d;
      wr_pend_q   <= wr_pend_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  assign adc_sdio_out = sdo_q;
  assign adc_sdio_oe  = oe_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_err    = frame_err_q;
  assign regs_flat    = regs_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: bit-banged initiator frames at sclk = clk/10,
// checked against a register-array model of the control port.
module tb_adc_spi_responder;

  localparam int         NUM_REGS  = 16;
  localparam logic [7:0] CHIP_ID   = 8'hA5;
  localparam logic [7:0] RESET_VAL = 8'h3C;

  logic clk = 1'b0, rst_n = 1'b0, csbn = 1'b1, sclk = 1'b0, sdio = 1'b0;
  logic sdio_out, sdio_oe, wr_strobe, frame_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [NUM_REGS*8-1:0] regs_flat;

  adc_spi_responder #(.NUM_REGS(NUM_REGS), .CHIP_ID(CHIP_ID), .RESET_VAL(RESET_VAL)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .adc_csbn(csbn), .adc_sclk(sclk),
    .adc_sdio_in(sdio), .adc_sdio_out(sdio_out), .adc_sdio_oe(sdio_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .regs_flat(regs_flat), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int wr_cnt = 0, ferr_cnt = 0;
  always @(posedge clk) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] model [NUM_REGS];

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = (i == 0) ? CHIP_ID : RESET_VAL;
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
    int ai = int'(a);
    if (ai != 0 && ai < NUM_REGS) model[ai] = d;
  endfunction

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    int ai = int'(a);
    if (ai == 0) return CHIP_ID;
    if (ai < NUM_REGS) return model[ai];
    return 8'h00;
  endfunction

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  task automatic cw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic so, output logic soe);
    sdio = b;
    cw(5);
    sclk = 1'b1;
    so  = sdio_out;
    soe = sdio_oe;
    cw(5);
    sclk = 1'b0;
  endtask

  // One frame of nbits; reports read byte, misplaced-oe count, oe after the
  // last fall, and how many strobes/frame errors the frame produced.
  task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [7:0] rd,
                           output int oe_bad, output logic oe_end, output int strobes,
                           output int ferrs);
    logic so, soe;
    int wc0, fc0;
    wc0 = wr_cnt; fc0 = ferr_cnt;
    rd = 8'h00; oe_bad = 0;
    csbn = 1'b0;
    cw(5);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(w[15-i], so, soe);
      if (i >= 8) rd = {rd[6:0], so};
      if (soe !== (w[15] && i >= 8)) oe_bad++;
    end
    cw(5);
    oe_end = sdio_oe;
    csbn = 1'b1;
    cw(6);
    strobes = wr_cnt - wc0;
    ferrs   = ferr_cnt - fc0;
  endtask

  logic [7:0] rd;
  int oe_bad, st, fe;
  logic oe_end;

  task automatic test_reset();
    model_reset();
    cw(2);
    n_cmp++; if (sdio_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", sdio_oe); end
    n_cmp++; if ({wr_strobe, frame_err, sdio_out} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {wr_strobe, frame_err, sdio_out}); end
    n_cmp++; if ({wr_addr, wr_data} !== 15'd0) begin n_bad++; $display("FAIL reset_wr got %h/%h want 0/0", wr_addr, wr_data); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_bad++; $display("FAIL reset_regs got %h want %h", regs_flat, model_flat()); end
    rst_n = 1'b1;
    cw(4);
  endtask

  task automatic test_write_basic();
    spi_frame(16'h035C, 16, rd, oe_bad, oe_end, st, fe);
    model_write(7'h03, 8'h5C);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL wr03_strobes got %0d want 1", st); end
    n_cmp++; if ({wr_addr, wr_data} !== {7'h03, 8'h5C}) begin n_bad++; $display("FAIL wr03_addr_data got %h/%h want 03/5c", wr_addr, wr_data); end
    n_cmp++; if (regs_flat[31:24] !== 8'h5C) begin n_bad++; $display("FAIL wr03_reg got %h want 5c", regs_flat[31:24]); end
    n_cmp++; if (oe_bad !== 0 || oe_end !== 1'b0) begin n_bad++; $display("FAIL wr03_oe got bad=%0d end=%b want 0/0", oe_bad, oe_end); end
  endtask

  task automatic test_read_basic();
    spi_frame(16'h8300, 16, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (rd !== exp_read(7'h03)) begin n_bad++; $display("FAIL rd03_data got %h want %h", rd, exp_read(7'h03)); end
    n_cmp++; if (oe_bad !== 0) begin n_bad++; $display("FAIL rd03_oe_window got %0d bad bits want 0", oe_bad); end
    n_cmp++; if (oe_end !== 1'b0) begin n_bad++; $display("FAIL rd03_oe_release got %b want 0", oe_end); end
    n_cmp++; if (st !== 0 || fe !== 0) begin n_bad++; $display("FAIL rd03_pulses got st=%0d fe=%0d want 0/0", st, fe); end
  endtask

  task automatic test_chip_id();
    spi_frame(16'h8000, 16, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (rd !== CHIP_ID) begin n_bad++; $display("FAIL id_read1 got %h want %h", rd, CHIP_ID); end
    spi_frame(16'h00FF, 16, rd, oe_bad, oe_end, st, fe);
    model_write(7'h00, 8'hFF);
    n_cmp++; if (st !== 1 || wr_data !== 8'hFF) begin n_bad++; $display("FAIL id_write got st=%0d data=%h want 1/ff", st, wr_data); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_bad++; $display("FAIL id_regs got %h want %h", regs_flat, model_flat()); end
    spi_frame(16'h8000, 16, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (rd !== CHIP_ID) begin n_bad++; $display("FAIL id_read2 got %h want %h", rd, CHIP_ID); end
  endtask

  task automatic test_out_of_range();
    spi_frame(16'hA000, 16, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (rd !== exp_read(7'h20) || oe_bad !== 0) begin n_bad++; $display("FAIL oor_read got %h bad=%0d want %h/0", rd, oe_bad, exp_read(7'h20)); end
    spi_frame(16'h2011, 16, rd, oe_bad, oe_end, st, fe);
    model_write(7'h20, 8'h11);
    n_cmp++; if (st !== 1 || wr_addr !== 7'h20) begin n_bad++; $display("FAIL oor_write got st=%0d addr=%h want 1/20", st, wr_addr); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_bad++; $display("FAIL oor_regs got %h want %h", regs_flat, model_flat()); end
  endtask

  task automatic test_abort();
    spi_frame(16'h0577, 11, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (fe !== 1 || st !== 0) begin n_bad++; $display("FAIL abort_pulses got fe=%0d st=%0d want 1/0", fe, st); end
    n_cmp++; if (regs_flat[47:40] !== RESET_VAL) begin n_bad++; $display("FAIL abort_reg5 got %h want %h", regs_flat[47:40], RESET_VAL); end
    spi_frame(16'h0000, 0, rd, oe_bad, oe_end, st, fe);
    n_cmp++; if (fe !== 0 || st !== 0) begin n_bad++; $display("FAIL empty_frame got fe=%0d st=%0d want 0/0", fe, st); end
    spi_frame(16'h0577, 16, rd, oe_bad, oe_end, st, fe);
    model_write(7'h05, 8'h77);
    n_cmp++; if (st !== 1 || fe !== 0 || regs_flat !== model_flat()) begin n_bad++; $display("FAIL post_abort_write got st=%0d fe=%0d reg5=%h want 1/0/77", st, fe, regs_flat[47:40]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 31));
      d  = 8'($urandom);
      spi_frame({rw, a, d}, 16, rd, oe_bad, oe_end, st, fe);
      if (rw) begin
        n_cmp++; if (rd !== exp_read(a) || st !== 0) begin n_bad++; $display("FAIL rand_read a=%h got %h st=%0d want %h/0", a, rd, st, exp_read(a)); end
      end else begin
        model_write(a, d);
        n_cmp++; if (st !== 1 || wr_addr !== a || wr_data !== d) begin n_bad++; $display("FAIL rand_write st=%0d got %h/%h want %h/%h", st, wr_addr, wr_data, a, d); end
      end
      n_cmp++; if (regs_flat !== model_flat() || oe_bad !== 0 || oe_end !== 1'b0 || fe !== 0) begin
        n_bad++; $display("FAIL rand_state n=%0d regs=%h want %h oe_bad=%0d oe_end=%b fe=%0d", n, regs_flat, model_flat(), oe_bad, oe_end, fe);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic so, soe, pre_oe;
    logic [15:0] w;
    int oe_seen, wc0, fc0;
    w = 16'h8300;
    csbn = 1'b0;
    cw(5);
    for (int i = 0; i < 12; i++) spi_bit(w[15-i], so, soe);
    sdio = 1'b0;
    cw(2);
    pre_oe = sdio_oe;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (pre_oe !== 1'b1 || sdio_oe !== 1'b0) begin n_bad++; $display("FAIL mid_reset_oe got before=%b after=%b want 1/0", pre_oe, sdio_oe); end
    n_cmp++; if (regs_flat !== model_flat()) begin n_bad++; $display("FAIL mid_reset_regs got %h want %h", regs_flat, model_flat()); end
    cw(3);
    rst_n = 1'b1;
    cw(3);
    wc0 = wr_cnt; fc0 = ferr_cnt; oe_seen = 0;
    for (int i = 0; i < 4; i++) begin spi_bit(1'b1, so, soe); if (soe) oe_seen++; end
    csbn = 1'b1;
    cw(6);
    n_cmp++; if (oe_seen !== 0 || wr_cnt != wc0 || ferr_cnt != fc0) begin
      n_bad++; $display("FAIL mid_reset_ignore got oe=%0d st=%0d fe=%0d want 0/0/0", oe_seen, wr_cnt - wc0, ferr_cnt - fc0);
    end
    spi_frame(16'h0142, 16, rd, oe_bad, oe_end, st, fe);
    model_write(7'h01, 8'h42);
    n_cmp++; if (st !== 1 || regs_flat[15:8] !== 8'h42 || regs_flat !== model_flat()) begin
      n_bad++; $display("FAIL post_reset_write got st=%0d reg1=%h want 1/42", st, regs_flat[15:8]);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_chip_id();
    test_out_of_range();
    test_abort();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
